// File: rtl/noc_flit_pkg.sv
// Flit encoding and arbiter state definitions shared by the NoC switch blocks.
package noc_flit_pkg;

    // Flit type lives in data[1:0].
    typedef enum logic [1:0] {
        FlitBody   = 2'b00,
        FlitHead   = 2'b01,
        FlitTail   = 2'b10,
        FlitSingle = 2'b11
    } flit_type_e;

    localparam int unsigned FLIT_TYPE_LSB = 0;
    localparam int unsigned FLIT_TYPE_MSB = 1;

    // Head flit routing fields.
    localparam int unsigned LOC_LSB = 2;
    localparam int unsigned LOC_MSB = 4;
    localparam int unsigned Y_LSB   = 5;
    localparam int unsigned Y_MSB   = 8;
    localparam int unsigned X_LSB   = 9;
    localparam int unsigned X_MSB   = 12;

    typedef enum logic [1:0] {
        StIdle,
        StWaitDw,
        StHold
    } arb_state_e;

    // HEAD and SINGLE both open a packet.
    function automatic logic is_head(input flit_type_e t);
        return (t == FlitHead) || (t == FlitSingle);
    endfunction

    // TAIL and SINGLE both close a packet.
    function automatic logic is_tail(input flit_type_e t);
        return (t == FlitTail) || (t == FlitSingle);
    endfunction

endpackage

// File: rtl/wormhole_out_arbiter_if.sv
// Channel bundle for one switch output port: NUM_IN 2-phase inputs, one 2-phase output.
interface wormhole_out_arbiter_if #(
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned NUM_IN     = 4
);
    logic [NUM_IN-1:0]                 req_in_i;
    logic [NUM_IN-1:0][WORD_WIDTH-1:0] data_in_i;
    logic [NUM_IN-1:0]                 ack_in_o;
    logic                              req_out_o;
    logic [WORD_WIDTH-1:0]             data_out_o;
    logic                              ack_out_i;
    logic [NUM_IN-1:0]                 grant_o;
    logic                              tailpassed_o;
    logic                              err_o;

    // Environment side: upstream buffers and downstream port.
    modport master (
        output req_in_i, data_in_i, ack_out_i,
        input  ack_in_o, req_out_o, data_out_o, grant_o, tailpassed_o, err_o
    );

    // Arbiter side.
    modport slave (
        input  req_in_i, data_in_i, ack_out_i,
        output ack_in_o, req_out_o, data_out_o, grant_o, tailpassed_o, err_o
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first request after ptr_i, wrapping, wins.
module rr_arbiter #(
    parameter int unsigned NUM_IN = 4,
    parameter int unsigned IdxW   = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic [NUM_IN-1:0] req_i,
    input  logic [IdxW-1:0]   ptr_i,
    output logic [NUM_IN-1:0] gnt_o,
    output logic [IdxW-1:0]   idx_o,
    output logic              valid_o
);
    logic [IdxW-1:0] probe;

    // Search ptr_i+1 .. ptr_i+NUM_IN; ptr_i itself is checked last.
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        probe   = '0;
        for (int unsigned off = 1; off <= NUM_IN; off++) begin
            probe = IdxW'((32'(ptr_i) + off) % NUM_IN);
            if (!valid_o && req_i[probe]) begin
                valid_o      = 1'b1;
                idx_o        = probe;
                gnt_o[probe] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/sync_cell.sv
// Shared multi-flop synchronizer cell for a single asynchronous bit.
module sync_cell #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);
    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // Shift the raw input one stage deeper each cycle.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d_i};
    end

    // Synchronizer chain, cleared by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/wormhole_out_arbiter.sv
// Wormhole output arbiter: round-robin on head flits, holds the output until the tail
// flit has been acknowledged downstream. All channels use 2-phase bundled data.
module wormhole_out_arbiter
    import noc_flit_pkg::*;
#(
    parameter int unsigned WORD_WIDTH  = 32,
    parameter int unsigned NUM_IN      = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic             clk,
    input logic             reset,
    wormhole_out_arbiter_if.slave bus
);
    localparam int unsigned IdxW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    logic [NUM_IN-1:0]     sync_req;
    logic                  sync_ack_out;
    logic [NUM_IN-1:0]     pending;
    logic [NUM_IN-1:0]     cand;
    logic [NUM_IN-1:0]     stray;
    logic                  down_done;
    logic [NUM_IN-1:0]     arb_gnt;
    logic [IdxW-1:0]       arb_idx;
    logic                  arb_valid;

    arb_state_e            state_q, state_d;
    logic [NUM_IN-1:0]     ack_in_q, ack_in_d;
    logic                  req_out_q, req_out_d;
    logic [WORD_WIDTH-1:0] data_out_q, data_out_d;
    logic [NUM_IN-1:0]     grant_q, grant_d;
    logic [IdxW-1:0]       owner_q, owner_d;
    logic [IdxW-1:0]       rr_ptr_q, rr_ptr_d;
    logic                  tailpassed_q, tailpassed_d;
    logic                  err_q, err_d;

    for (genvar i = 0; i < NUM_IN; i++) begin : g_sync_req
        sync_cell #(.STAGES(SYNC_STAGES)) u_sync_req (
            .clk   (clk),
            .reset (reset),
            .d_i   (bus.req_in_i[i]),
            .q_o   (sync_req[i])
        );
    end

    sync_cell #(.STAGES(SYNC_STAGES)) u_sync_ack (
        .clk   (clk),
        .reset (reset),
        .d_i   (bus.ack_out_i),
        .q_o   (sync_ack_out)
    );

    assign pending   = sync_req ^ ack_in_q;
    assign down_done = (sync_ack_out == req_out_q);

    // Split pending inputs into packet openers and flits that arrived without a lock.
    always_comb begin
        cand  = '0;
        stray = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (is_head(flit_type_e'(bus.data_in_i[i][FLIT_TYPE_MSB:FLIT_TYPE_LSB]))) begin
                cand[i]  = pending[i];
            end else begin
                stray[i] = pending[i];
            end
        end
    end

    rr_arbiter #(.NUM_IN(NUM_IN), .IdxW(IdxW)) u_rr_arbiter (
        .req_i   (cand),
        .ptr_i   (rr_ptr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    // Next-state: lock on a head, forward one flit per downstream round trip, release on tail.
    always_comb begin
        state_d      = state_q;
        ack_in_d     = ack_in_q;
        req_out_d    = req_out_q;
        data_out_d   = data_out_q;
        grant_d      = grant_q;
        owner_d      = owner_q;
        rr_ptr_d     = rr_ptr_q;
        tailpassed_d = 1'b0;
        err_d        = err_q;
        unique case (state_q)
            StIdle: begin
                if (|stray) begin
                    err_d = 1'b1;
                end
                if (arb_valid) begin
                    grant_d    = arb_gnt;
                    owner_d    = arb_idx;
                    data_out_d = bus.data_in_i[arb_idx];
                    req_out_d  = ~req_out_q;
                    state_d    = StWaitDw;
                end
            end
            StWaitDw: begin
                if (down_done) begin
                    ack_in_d[owner_q] = ~ack_in_q[owner_q];
                    if (is_tail(flit_type_e'(data_out_q[FLIT_TYPE_MSB:FLIT_TYPE_LSB]))) begin
                        grant_d      = '0;
                        rr_ptr_d     = owner_q;
                        tailpassed_d = 1'b1;
                        state_d      = StIdle;
                    end else begin
                        state_d = StHold;
                    end
                end
            end
            StHold: begin
                if (pending[owner_q]) begin
                    data_out_d = bus.data_in_i[owner_q];
                    req_out_d  = ~req_out_q;
                    // A second head inside a packet is forwarded but flagged.
                    if (flit_type_e'(bus.data_in_i[owner_q][FLIT_TYPE_MSB:FLIT_TYPE_LSB])
                        == FlitHead) begin
                        err_d = 1'b1;
                    end
                    state_d = StWaitDw;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers; rr_ptr resets to NUM_IN-1 so port 0 is searched first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            ack_in_q     <= '0;
            req_out_q    <= 1'b0;
            data_out_q   <= '0;
            grant_q      <= '0;
            owner_q      <= '0;
            rr_ptr_q     <= IdxW'(NUM_IN - 1);
            tailpassed_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            ack_in_q     <= ack_in_d;
            req_out_q    <= req_out_d;
            data_out_q   <= data_out_d;
            grant_q      <= grant_d;
            owner_q      <= owner_d;
            rr_ptr_q     <= rr_ptr_d;
            tailpassed_q <= tailpassed_d;
            err_q        <= err_d;
        end
    end

    assign bus.ack_in_o     = ack_in_q;
    assign bus.req_out_o    = req_out_q;
    assign bus.data_out_o   = data_out_q;
    assign bus.grant_o      = grant_q;
    assign bus.tailpassed_o = tailpassed_q;
    assign bus.err_o        = err_q;
endmodule

// File: tb/tb_wormhole_out_arbiter.sv
// Directed bench for wormhole_out_arbiter: scoreboard of expected output flits,
// 2-phase upstream drivers and a downstream responder with configurable ack delay.
module tb_wormhole_out_arbiter;
    localparam int unsigned W = 32;
    localparam int unsigned N = 4;
    localparam int unsigned S = 2;

    typedef struct packed {
        logic [W-1:0] data;
        logic [N-1:0] grant;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic [N-1:0]        up_req;
    logic [N-1:0][W-1:0] up_data;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   tp_cnt = 0;
    int   tp_first_cyc = -1;
    int   ack2_first_cyc = -1;
    int   dn_ack_cyc = 0;
    int   ack_delay = 0;
    bit   lag_en = 1'b0;
    int   tp_base;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    wormhole_out_arbiter_if #(.WORD_WIDTH(W), .NUM_IN(N)) bus ();

    assign bus.req_in_i  = up_req;
    assign bus.data_in_i = up_data;

    wormhole_out_arbiter #(.WORD_WIDTH(W), .NUM_IN(N), .SYNC_STAGES(S)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int p, input logic [W-1:0] d);
        exp_t e;
        e.data  = d;
        e.grant = N'(1) << p;
        exp_q.push_back(e);
    endtask

    function automatic logic [W-1:0] mkf(input int p, input int r, input logic [1:0] t);
        return W'(32'hA000_0000 | (p << 12) | (r << 8)) | {30'b0, t};
    endfunction

    // Present one flit on port p and wait (bounded) for its acknowledge.
    task automatic send_flit(input int p, input logic [W-1:0] d);
        bit got;
        @(posedge clk);
        #1;
        up_data[p] = d;
        up_req[p]  = ~up_req[p];
        got = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk);
            #1;
            if (bus.ack_in_o[p] == up_req[p]) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_vec++;
            n_err++;
            $display("FAIL ack_timeout port %0d: got no ack, expected one within 400 cycles", p);
        end
    endtask

    task automatic raise_flit(input int p, input logic [W-1:0] d);
        @(posedge clk);
        #1;
        up_data[p] = d;
        up_req[p]  = ~up_req[p];
    endtask

    task automatic run_port(input int p);
        for (int r = 0; r < 2; r++) begin
            send_flit(p, mkf(p, r, 2'b01));
            send_flit(p, mkf(p, r, 2'b10));
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset   = 1'b1;
        up_req  = '0;
        up_data = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ack_in"}, 64'(bus.ack_in_o), 64'd0);
        check({tag, "_req_out"}, 64'(bus.req_out_o), 64'd0);
        check({tag, "_data_out"}, 64'(bus.data_out_o), 64'd0);
        check({tag, "_grant"}, 64'(bus.grant_o), 64'd0);
        check({tag, "_tailpassed"}, 64'(bus.tailpassed_o), 64'd0);
        check({tag, "_err"}, 64'(bus.err_o), 64'd0);
    endtask

    // Downstream responder: acknowledges each req_out toggle after ack_delay cycles.
    initial begin
        bus.ack_out_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                bus.ack_out_i = 1'b0;
            end else if (bus.req_out_o != bus.ack_out_i) begin
                repeat (ack_delay) @(posedge clk);
                #1;
                if (!reset && bus.req_out_o != bus.ack_out_i) begin
                    bus.ack_out_i = ~bus.ack_out_i;
                    dn_ack_cyc    = cyc;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every req_out toggle, tracks pulses and ack timing.
    initial begin
        logic          prev_req;
        logic          prev_ack;
        logic          prev_tp;
        logic [N-1:0]  prev_ackin;
        exp_t          e;
        prev_req   = 1'b0;
        prev_ack   = 1'b0;
        prev_tp    = 1'b0;
        prev_ackin = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_req   = 1'b0;
                prev_ack   = 1'b0;
                prev_tp    = 1'b0;
                prev_ackin = '0;
            end else begin
                if (bus.req_out_o !== prev_req) begin
                    check("req_out_after_down_ack", 64'(prev_ack), 64'(prev_req));
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_flit: got data %0h, expected no flit",
                                 bus.data_out_o);
                    end else begin
                        e = exp_q.pop_front();
                        check("flit_data", 64'(bus.data_out_o), 64'(e.data));
                        check("flit_grant", 64'(bus.grant_o), 64'(e.grant));
                    end
                end
                if (bus.tailpassed_o && prev_tp) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL tailpassed_width: got 2+ cycle pulse, expected 1 cycle");
                end
                if (bus.tailpassed_o && !prev_tp) begin
                    tp_cnt++;
                    if (tp_first_cyc < 0) tp_first_cyc = cyc;
                end
                for (int i = 0; i < N; i++) begin
                    if (bus.ack_in_o[i] !== prev_ackin[i]) begin
                        if (lag_en) check("ack_in_lag", 64'(cyc - dn_ack_cyc), 64'(S + 1));
                        if (i == 2 && ack2_first_cyc < 0) ack2_first_cyc = cyc;
                    end
                end
                prev_req   = bus.req_out_o;
                prev_tp    = bus.tailpassed_o;
                prev_ackin = bus.ack_in_o;
            end
            prev_ack = bus.ack_out_i;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset   = 1'b1;
        up_req  = '0;
        up_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        reset = 1'b0;

        // Single 4-flit packet on port 0, immediate downstream acks.
        tp_base = tp_cnt;
        push(0, 32'h0000_0401);
        push(0, 32'h0000_0000);
        push(0, 32'hFFFF_FFFC);
        push(0, 32'h0000_0002);
        send_flit(0, 32'h0000_0401);
        send_flit(0, 32'h0000_0000);
        send_flit(0, 32'hFFFF_FFFC);
        repeat (3) @(posedge clk);
        check("t1_no_tail_yet", 64'(tp_cnt - tp_base), 64'd0);
        send_flit(0, 32'h0000_0002);
        repeat (3) @(posedge clk);
        check("t1_tailpassed", 64'(tp_cnt - tp_base), 64'd1);
        check("t1_all_flits", 64'(exp_q.size()), 64'd0);
        check("t1_grant_released", 64'(bus.grant_o), 64'd0);
        check("t1_err", 64'(bus.err_o), 64'd0);

        // Ports 1 and 2 head in the same cycle: port 1 wins, port 2 waits for its tail.
        do_reset();
        tp_first_cyc   = -1;
        ack2_first_cyc = -1;
        tp_base        = tp_cnt;
        push(1, mkf(1, 0, 2'b01));
        push(1, mkf(1, 0, 2'b10));
        push(2, mkf(2, 0, 2'b01));
        push(2, mkf(2, 0, 2'b10));
        fork
            begin send_flit(1, mkf(1, 0, 2'b01)); send_flit(1, mkf(1, 0, 2'b10)); end
            begin send_flit(2, mkf(2, 0, 2'b01)); send_flit(2, mkf(2, 0, 2'b10)); end
        join
        repeat (3) @(posedge clk);
        check("t2_p2_acked_after_p1_tail", 64'(ack2_first_cyc > tp_first_cyc), 64'd1);
        check("t2_all_flits", 64'(exp_q.size()), 64'd0);
        check("t2_tailpassed", 64'(tp_cnt - tp_base), 64'd2);

        // All ports stream 2-flit packets: grant order 0,1,2,3,0,1,2,3.
        do_reset();
        tp_base = tp_cnt;
        for (int r = 0; r < 2; r++) begin
            for (int p = 0; p < N; p++) begin
                push(p, mkf(p, r, 2'b01));
                push(p, mkf(p, r, 2'b10));
            end
        end
        fork
            run_port(0);
            run_port(1);
            run_port(2);
            run_port(3);
        join
        repeat (3) @(posedge clk);
        check("t3_all_flits", 64'(exp_q.size()), 64'd0);
        check("t3_tailpassed", 64'(tp_cnt - tp_base), 64'd8);
        check("t3_err", 64'(bus.err_o), 64'd0);

        // Slow downstream: 20-cycle ack delay, ack_in follows by SYNC_STAGES+1 clocks.
        do_reset();
        tp_base   = tp_cnt;
        ack_delay = 20;
        lag_en    = 1'b1;
        push(2, 32'h0000_1201);
        push(2, 32'h1234_5670);
        push(2, 32'h89AB_CDE0);
        push(2, 32'h0000_0012);
        send_flit(2, 32'h0000_1201);
        send_flit(2, 32'h1234_5670);
        send_flit(2, 32'h89AB_CDE0);
        send_flit(2, 32'h0000_0012);
        repeat (3) @(posedge clk);
        lag_en    = 1'b0;
        ack_delay = 0;
        check("t4_all_flits", 64'(exp_q.size()), 64'd0);
        check("t4_tailpassed", 64'(tp_cnt - tp_base), 64'd1);

        // Stray BODY on port 3 while unlocked: error, never acked, port 0 still served.
        do_reset();
        raise_flit(3, 32'h0000_3000);
        repeat (5) @(posedge clk);
        #1;
        check("t5_err_set", 64'(bus.err_o), 64'd1);
        push(0, 32'h0000_0201);
        push(0, 32'h0000_0202);
        send_flit(0, 32'h0000_0201);
        send_flit(0, 32'h0000_0202);
        repeat (3) @(posedge clk);
        check("t5_all_flits", 64'(exp_q.size()), 64'd0);
        check("t5_port3_not_acked", 64'(bus.ack_in_o[3]), 64'd0);
        check("t5_err_sticky", 64'(bus.err_o), 64'd1);

        // Reset mid-packet drops the lock at once; a new packet then completes.
        do_reset();
        push(0, 32'h0000_0601);
        push(0, 32'h5555_AAA4);
        send_flit(0, 32'h0000_0601);
        send_flit(0, 32'h5555_AAA4);
        check("t6_locked_before_reset", 64'(bus.grant_o), 64'd1);
        reset   = 1'b1;
        up_req  = '0;
        up_data = '0;
        #1;
        check_reset_values("t6_async");
        repeat (3) @(posedge clk);
        #1;
        reset   = 1'b0;
        tp_base = tp_cnt;
        push(1, 32'h0000_0801);
        push(1, 32'h0000_0802);
        send_flit(1, 32'h0000_0801);
        send_flit(1, 32'h0000_0802);
        repeat (3) @(posedge clk);
        check("t6_all_flits", 64'(exp_q.size()), 64'd0);
        check("t6_tailpassed", 64'(tp_cnt - tp_base), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/wormhole_out_arbiter.md
Name: wormhole_out_arbiter

Overview:
- Clocked controller that shares one switch output channel between NUM_IN upstream input channels.
- Protocol on every channel: 2-phase bundled-data (req toggles = new flit; ack toggles = flit consumed).
- Arbitration is round-robin on head flits; the granted input keeps the output locked from head through tail (wormhole).
- Sits between the switch input buffers and one output port; one instance per output port.

Parameters:
- WORD_WIDTH, 32, flit width; bits [1:0] are the flit type.
- NUM_IN, 4, number of competing input channels.
- SYNC_STAGES, 2, synchronizer depth on the async req/ack inputs (minimum 2).

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high reset.
- req_in_i  in  NUM_IN  2-phase request per input.
- data_in_i  in  NUM_IN x WORD_WIDTH  bundled flit per input.
- ack_in_o  out  NUM_IN  2-phase acknowledge per input.
- req_out_o  out  1  2-phase request to downstream.
- data_out_o  out  WORD_WIDTH  registered flit to downstream.
- ack_out_i  in  1  2-phase acknowledge from downstream.
- grant_o  out  NUM_IN  one-hot current owner; all zero when unlocked.
- tailpassed_o  out  1  one-cycle pulse when the tail flit is acked downstream.
- err_o  out  1  sticky protocol error flag.

Behaviour:
- Reset values: ack_in_o=0, req_out_o=0, data_out_o=0, grant_o=0, tailpassed_o=0, err_o=0, state=IDLE, rr_ptr=NUM_IN-1 (port 0 has first priority). All synchronizer flops clear.
- Flit type, data[1:0]: 01=HEAD, 00=BODY, 10=TAIL, 11=SINGLE (head+tail).
- req_in_i and ack_out_i each pass through a SYNC_STAGES flop chain.
- pending[i] = sync_req[i] != ack_in_o[i]. down_done = sync_ack_out == req_out_o.
- Data is sampled only after the synced req shows a change; synchronizer delay provides the bundling margin.
- IDLE state:
  - Candidates are inputs with pending=1 and type HEAD or SINGLE.
  - Winner w is the first candidate searching rr_ptr+1, rr_ptr+2, ... modulo NUM_IN.
  - At that edge: grant_o=onehot(w), data_out_o<=data_in_i[w], req_out_o toggles, next state WAIT_DW.
  - Pending BODY or TAIL flits on ungranted inputs are never acked and set err_o.
- WAIT_DW state:
  - When down_done: ack_in_o[w] toggles.
  - If the forwarded flit was TAIL or SINGLE: grant_o<=0, rr_ptr<=w, tailpassed_o pulses for 1 cycle, next state IDLE.
  - Otherwise: next state HOLD.
- HOLD state:
  - When pending[w]: capture data_in_i[w], toggle req_out_o, next state WAIT_DW.
  - A HEAD arriving on w while locked is still forwarded, and sets err_o.
  - Other inputs are ignored while locked.
- Latency:
  - Synced pending head to req_out_o toggle: 1 cycle, so SYNC_STAGES+1 clocks from the raw req toggle.
  - Synced down_done to ack_in_o toggle: 1 cycle.
- Throughput: at most one flit per downstream round trip. No pipelining of flits.
- Simultaneous events:
  - Grant release and a new head on another input in the same cycle: the new head is seen in the following IDLE cycle (1 idle cycle minimum between packets).
  - Released owner w gets lowest priority next round.
- Reset asserted mid-packet: immediate return to reset values; any lock is dropped. Upstream and downstream must be reset together, because channel phase restarts at 0.
- grant_o and state are registered; no combinational path from any input to any output.

Decomposition:
- Package noc_flit_pkg holds:
  - flit_type_e enum (HEAD, BODY, TAIL, SINGLE) and FLIT_TYPE_LSB/MSB constants.
  - Head field positions: LOC [4:2], Y [8:5], X [12:9].
  - arb_state_e enum (IDLE, WAIT_DW, HOLD).
- Sub-module rr_arbiter: combinational request vector plus pointer in, one-hot grant out. Parameterised by NUM_IN.
- Synchronizers are instantiated from the existing shared 2-flop sync cell, generated per bit.

Test Plan:
- Port 0 sends HEAD(X=2,Y=0), BODY 0x0, BODY 0xFFFFFFFC, TAIL 0x2; downstream acks immediately. Required: 4 req_out_o toggles, data identical in order, grant_o=0001 throughout, one tailpassed_o pulse after the 4th ack.
- HEADs on ports 1 and 2 arrive in the same cycle after reset. Required: port 1 packet forwarded entirely before port 2; port 2 ack_in_o does not toggle until port 1 TAIL completes.
- All 4 ports continuously send 2-flit packets. Required: grant order 0,1,2,3,0, with no port skipped.
- Downstream delays each ack by 20 cycles. Required: req_out_o toggles exactly once per ack; no flit is lost or duplicated; ack_in_o lags the downstream ack by SYNC_STAGES+1 clocks.
- BODY flit pending on port 3 while unlocked. Required: err_o=1, port 3 never acked, port 0 HEAD still granted.
- reset pulsed after 2 of 4 flits. Required: all outputs return to reset values within the same cycle; a new packet afterwards completes normally.
